// File: rtl/grf_pkg.sv
// Shared constants for the parametrised general register file.
//   - default geometry (data width, address width, read ports, pending width)
//   - index of the hard-wired zero register
//   - writeback trace format, used only when GRF_TRACE_EN is defined
//   - pend_max(): largest value a PEND_W-bit pending counter can hold
package grf_pkg;

  localparam int GRF_DATA_W   = 32;
  localparam int GRF_ADDR_W   = 5;
  localparam int GRF_NUM_RD   = 2;
  localparam int GRF_PEND_W   = 2;
  localparam int GRF_ZERO_REG = 0;

  localparam string GRF_TRACE_FMT = "@%h: $%d <= %h";

  function automatic int pend_max(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction

endpackage

// File: rtl/grf_pend_ctr.sv
// Pending-write counter for one architectural register.
// Counts issued-but-not-written-back writes to the register.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   inc_i       an instruction targeting this register was issued
//   dec_i       writeback to this register (caller gates with !zero_o)
//   cnt_o       current in-flight count
//   full_o      counter at its maximum; caller must refuse further issues
//   zero_o      no writes in flight
module grf_pend_ctr
  import grf_pkg::*;
#(
  parameter int PEND_W = GRF_PEND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              full_o,
  output logic              zero_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));

  logic [PEND_W-1:0] cnt_q, cnt_d;

  // Saturation guards are defensive: the callers already gate inc with
  // !full and dec with !zero, so wrap-around can never be requested.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + PEND_W'(1);
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == CNT_MAX);
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/param_grf_sb.sv
// Parametrised general register file with write-through bypass and a
// per-register pending-write scoreboard, for the decode stage.
// Optional build macro: GRF_TRACE_EN prints every accepted writeback.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   we, wa, wd           writeback port
//   wpc                  PC of the writing instruction (trace only)
//   ra / rd              NUM_RD packed read addresses / read data
//   rd_busy              per read port: operand still has writes in flight
//   iss_valid, iss_addr  issue port marking a destination as in flight
//   iss_full             issue refused, pending counter of iss_addr saturated
//   sb_err               sticky: writeback to a register with nothing pending
module param_grf_sb
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = GRF_NUM_RD,
  parameter int PEND_W = GRF_PEND_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [31:0]              wpc,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_full,
  output logic                     sb_err
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(GRF_ZERO_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [PEND_W-1:0] cnt    [DEPTH];
  logic              full_v [DEPTH];
  logic              zero_v [DEPTH];
  logic              sb_err_q, sb_err_d;
  logic              wr_live;

  assign wr_live = we && (wa != ZERO_A);

  // Register 0 has no counter: it is never busy and never full.
  assign cnt[0]    = '0;
  assign full_v[0] = 1'b0;
  assign zero_v[0] = 1'b1;

  // A writeback to the same register frees a slot in the same cycle, so a
  // saturated counter still accepts the issue (net count unchanged).
  assign iss_full = iss_valid && (iss_addr != ZERO_A) && full_v[iss_addr]
                    && !(we && wa == iss_addr);

  for (genvar r = 1; r < DEPTH; r++) begin : g_ctr
    logic inc, dec;
    assign inc = iss_valid && (iss_addr == ADDR_W'(r)) && !iss_full;
    assign dec = we && (wa == ADDR_W'(r)) && !zero_v[r];

    grf_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (inc),
      .dec_i  (dec),
      .cnt_o  (cnt[r]),
      .full_o (full_v[r]),
      .zero_o (zero_v[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[wa] <= wd;
    end
  end

  assign sb_err_d = sb_err_q || (wr_live && zero_v[wa]);

  always_ff @(posedge clk) begin
    if (reset) sb_err_q <= 1'b0;
    else       sb_err_q <= sb_err_d;
  end

  assign sb_err = sb_err_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra_p;
    logic              hit;
    logic              credit;
    logic [PEND_W-1:0] left;

    assign ra_p   = ra[p*ADDR_W +: ADDR_W];
    assign hit    = we && (wa == ra_p);
    // The writeback retiring one pending write counts immediately, so an
    // operand whose last outstanding write is landing now is not busy.
    assign credit = hit && !zero_v[ra_p];
    assign left   = cnt[ra_p] - PEND_W'(credit);

    assign rd[p*DATA_W +: DATA_W] = (ra_p == ZERO_A) ? '0 :
                                    hit              ? wd : regs_q[ra_p];
    assign rd_busy[p] = (ra_p != ZERO_A) && (left != '0);
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && wr_live) begin
      $display("%s", $sformatf(GRF_TRACE_FMT, wpc, wa, wd));
    end
  end
`else
  logic unused_wpc;
  assign unused_wpc = ^wpc;
`endif

endmodule

// File: tb/tb_param_grf_sb.sv
module tb_param_grf_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int PW = 2;

  logic              clk;
  logic              reset;
  logic              we;
  logic [AW-1:0]     wa;
  logic [DW-1:0]     wd;
  logic [31:0]       wpc;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rd_busy;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic              iss_full;
  logic              sb_err;

  param_grf_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .wpc       (wpc),
    .ra        (ra),
    .rd        (rd),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_full  (iss_full),
    .sb_err    (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {O_RD0, O_RD1, O_BUSY0, O_BUSY1, O_FULL, O_ERR} obs_e;
  typedef struct {
    obs_e        sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic expect_val(input obs_e sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] observe(input obs_e sel);
    case (sel)
      O_RD0:   return rd[31:0];
      O_RD1:   return rd[63:32];
      O_BUSY0: return {31'b0, rd_busy[0]};
      O_BUSY1: return {31'b0, rd_busy[1]};
      O_FULL:  return {31'b0, iss_full};
      default: return {31'b0, sb_err};
    endcase
  endfunction

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Called at a negedge after inputs are driven: sample 1ns later, then
  // move on to the next negedge (the posedge happens in between).
  task automatic step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic set_ra(input int a0, input int a1);
    ra = {AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    we        = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; wpc = '0;
    ra = '0; iss_valid = 1'b0; iss_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state across all addresses on both ports
    for (int a = 0; a < 32; a++) begin
      set_ra(a, 31 - a);
      expect_val(O_RD0, 32'h0, "rst_rd0");
      expect_val(O_RD1, 32'h0, "rst_rd1");
      expect_val(O_BUSY0, 32'h0, "rst_busy0");
      expect_val(O_BUSY1, 32'h0, "rst_busy1");
      if (a == 0) begin
        expect_val(O_ERR, 32'h0, "rst_err");
        expect_val(O_FULL, 32'h0, "rst_full");
      end
      step();
    end

    // Issue $5, then write it with bypass
    iss_valid = 1'b1; iss_addr = 5; set_ra(5, 0);
    expect_val(O_BUSY0, 32'h0, "iss5_same_cycle_busy");
    step();
    iss_valid = 1'b0; we = 1'b1; wa = 5; wd = 32'hDEADBEEF; wpc = 32'h100;
    expect_val(O_BUSY0, 32'h0, "wb5_credit_busy");
    expect_val(O_RD0, 32'hDEADBEEF, "wb5_bypass");
    expect_val(O_RD1, 32'h0, "wb5_port1_zero");
    step();
    idle();
    expect_val(O_RD0, 32'hDEADBEEF, "reg5_next_cycle");
    expect_val(O_ERR, 32'h0, "err_after_wb5");
    step();

    // Writes to $0 are dropped
    we = 1'b1; wa = 0; wd = 32'h1234; wpc = 32'h104; set_ra(0, 5);
    expect_val(O_RD0, 32'h0, "zero_bypass_blocked");
    expect_val(O_RD1, 32'hDEADBEEF, "reg5_port1");
    step();
    idle();
    expect_val(O_RD0, 32'h0, "zero_reg_after_wr");
    expect_val(O_ERR, 32'h0, "err_after_w0");
    step();

    // Fill $7 to saturation
    set_ra(7, 7); iss_valid = 1'b1; iss_addr = 7;
    for (int k = 0; k < 3; k++) begin
      expect_val(O_BUSY0, (k != 0) ? 32'h1 : 32'h0, "busy7_fill_p0");
      expect_val(O_BUSY1, (k != 0) ? 32'h1 : 32'h0, "busy7_fill_p1");
      expect_val(O_FULL, 32'h0, "full7_fill");
      step();
    end
    expect_val(O_FULL, 32'h1, "iss_full7");
    expect_val(O_BUSY1, 32'h1, "busy7_sat");
    step();
    expect_val(O_FULL, 32'h1, "iss_full7_retry");
    step();

    // Issue and writeback together at saturation: accepted, count holds at 3
    we = 1'b1; wa = 7; wd = 32'hA0; wpc = 32'h108;
    expect_val(O_FULL, 32'h0, "full7_wb_credit");
    expect_val(O_RD1, 32'hA0, "wb7_a0_bypass");
    expect_val(O_BUSY1, 32'h1, "busy7_wb_credit");
    step();

    // Drain three writebacks; busy drops during the third
    iss_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wd = 32'hA0 + 32'(k);
      expect_val(O_BUSY1, (k < 3) ? 32'h1 : 32'h0, "busy7_drain");
      expect_val(O_RD0, 32'hA0 + 32'(k), "wb7_drain_bypass");
      if (k == 1) expect_val(O_FULL, 32'h0, "full_no_issue");
      step();
    end
    idle();
    expect_val(O_BUSY1, 32'h0, "busy7_drained");
    expect_val(O_RD1, 32'hA3, "reg7_final");
    expect_val(O_ERR, 32'h0, "err_after_drain7");
    step();

    // $9: same-cycle issue and writeback with cnt=1
    iss_valid = 1'b1; iss_addr = 9; set_ra(9, 9);
    expect_val(O_BUSY0, 32'h0, "iss9_same_cycle");
    step();
    we = 1'b1; wa = 9; wd = 32'h99;
    expect_val(O_BUSY0, 32'h0, "busy9_wb_credit");
    expect_val(O_RD0, 32'h99, "wb9_bypass");
    step();
    idle();
    expect_val(O_BUSY0, 32'h1, "busy9_cnt_held");
    expect_val(O_BUSY1, 32'h1, "busy9_cnt_held_p1");
    step();
    we = 1'b1; wa = 9; wd = 32'h9A;
    expect_val(O_BUSY0, 32'h0, "busy9_last_wb");
    step();
    idle();
    expect_val(O_BUSY0, 32'h0, "busy9_clear");
    expect_val(O_RD1, 32'h9A, "reg9_final");
    expect_val(O_ERR, 32'h0, "err_after_9");
    step();

    // Writeback to $3 with nothing pending: write lands, sb_err sticks
    we = 1'b1; wa = 3; wd = 32'hCAFE0003; set_ra(3, 3);
    expect_val(O_ERR, 32'h0, "err_not_yet");
    expect_val(O_RD0, 32'hCAFE0003, "wb3_bypass");
    step();
    idle();
    expect_val(O_ERR, 32'h1, "err_set");
    expect_val(O_RD1, 32'hCAFE0003, "reg3_written");
    step();
    expect_val(O_ERR, 32'h1, "err_sticky");
    step();

    // Two issues to $7, then reset with concurrent issue and write
    iss_valid = 1'b1; iss_addr = 7; set_ra(7, 3);
    step();
    expect_val(O_BUSY0, 32'h1, "busy7_before_reset");
    step();
    reset = 1'b1; we = 1'b1; wa = 3; wd = 32'hFFFF;
    #1;
    @(negedge clk);
    reset = 1'b0; idle();
    expect_val(O_BUSY0, 32'h0, "busy7_after_reset");
    expect_val(O_RD0, 32'h0, "reg7_after_reset");
    expect_val(O_RD1, 32'h0, "reg3_after_reset");
    expect_val(O_ERR, 32'h0, "err_after_reset");
    step();
    set_ra(5, 9);
    expect_val(O_RD0, 32'h0, "reg5_after_reset");
    expect_val(O_BUSY1, 32'h0, "busy9_after_reset");
    step();

    // Counter restarts from 0: a single issue makes $7 busy, not full
    iss_valid = 1'b1; iss_addr = 7; set_ra(7, 7);
    expect_val(O_FULL, 32'h0, "full7_after_reset");
    step();
    idle();
    expect_val(O_BUSY1, 32'h1, "busy7_reissue");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
